// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan controller.
// N_DIGITS BCD digits share one 8-bit segment bus (bit7 = DP). A shadow copy of
// the BCD/DP word is taken only at frame boundaries (or while idle) via a
// LOAD/LOAD_ACK handshake, so a frame is never torn.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shown). Undefined by default.
module seg_scan_ctrl #(
  parameter int N_DIGITS    = 2,
  parameter int DIV_TICKS   = 1000,
  parameter int BLANK_TICKS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*N_DIGITS-1:0] BCD_IN,
  input  logic [N_DIGITS-1:0]   DP_IN,
  output logic [7:0]            SEG,
  output logic [N_DIGITS-1:0]   DIG,
  output logic                  LOAD_ACK
);

  localparam int TW = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;
  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state;
  logic [TW-1:0]         tick_p0;
  logic [SW-1:0]         slot_p0;
  logic [4*N_DIGITS-1:0] shadow_bcd;
  logic [N_DIGITS-1:0]   shadow_dp;

  logic [7:0]            seg_p1;
  logic [N_DIGITS-1:0]   dig_p1;
  logic                  ack_p1;

  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic [N_DIGITS-1:0]   dig_cur;
  logic                  cur_blank;
  logic [7:0]            seg_cur;
  logic                  tick_last;
  logic                  frame_end;
  logic                  in_blank;

  // BCD to segments (g..a); codes 10..15 render as a dash
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  assign tick_last = (tick_p0 == TW'(DIV_TICKS - 1));
  assign frame_end = tick_last && (slot_p0 == SW'(N_DIGITS - 1));
  assign in_blank  = (tick_p0 < TW'(BLANK_TICKS));

  // Select the shadow digit and one-hot strobe for the current slot
  always_comb begin
    cur_bcd = 4'd0;
    cur_dp  = 1'b0;
    dig_cur = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (slot_p0 == SW'(k)) begin
        cur_bcd    = shadow_bcd[4*k +: 4];
        cur_dp     = shadow_dp[k];
        dig_cur[k] = 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_blank;
  logic                zero_above;

  // A digit above 0 is blank when it and all higher digits are 0 with no DP
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (shadow_bcd[4*k +: 4] == 4'd0) && !shadow_dp[k];
      if (k > 0) lz_blank[k] = zero_above;
    end
  end

  assign cur_blank = |(lz_blank & dig_cur);
`else
  assign cur_blank = 1'b0;
`endif

  assign seg_cur = cur_blank ? 8'h00 : {cur_dp, decode7(cur_bcd)};

  // Scan FSM, tick/slot counters, snapshot capture and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      tick_p0    <= '0;
      slot_p0    <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      seg_p1     <= 8'h00;
      dig_p1     <= '0;
      ack_p1     <= 1'b0;
    end else begin
      ack_p1 <= 1'b0;
      case (state)
        IDLE: begin
          tick_p0 <= '0;
          slot_p0 <= '0;
          seg_p1  <= 8'h00;
          dig_p1  <= '0;
          if (LOAD) begin
            shadow_bcd <= BCD_IN;
            shadow_dp  <= DP_IN;
            ack_p1     <= 1'b1;
          end
          if (EN) state <= SCAN;
        end
        SCAN: begin
          // capture happens even if EN drops on the same frame-end edge
          if (frame_end && LOAD) begin
            shadow_bcd <= BCD_IN;
            shadow_dp  <= DP_IN;
            ack_p1     <= 1'b1;
          end
          if (!EN) begin
            state   <= IDLE;
            tick_p0 <= '0;
            slot_p0 <= '0;
            seg_p1  <= 8'h00;
            dig_p1  <= '0;
          end else begin
            if (tick_last) begin
              tick_p0 <= '0;
              slot_p0 <= (slot_p0 == SW'(N_DIGITS - 1)) ? '0 : slot_p0 + SW'(1);
            end else begin
              tick_p0 <= tick_p0 + TW'(1);
            end
            // stage p0 -> p1: outputs follow tick/slot by one register
            if (in_blank) begin
              seg_p1 <= 8'h00;
              dig_p1 <= '0;
            end else begin
              seg_p1 <= seg_cur;
              dig_p1 <= dig_cur;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SEG      = seg_p1;
  assign DIG      = dig_p1;
  assign LOAD_ACK = ack_p1;

endmodule
